clk_period_meter: RTL and testbench

Measures the half-periods and full period of a slow square wave, such as the output of the team's clock divider, in cycles of the reference clock `clock_in`. It is the counterpart of the divider: the divider turns a count into a toggling clock, and this block recovers the count from the toggling signal. It sits in frequency-check and self-test logic. It reports high-phase length, low-phase length, period, a lock indication and a loss-of-signal timeout.

---
 rtl/clk_meas_pkg.sv | 19 +
 rtl/bit_sync.sv | 32 +++
 rtl/clk_period_meter.sv | 174 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// ---------------------------------------------------------------------------
// clk_meas_pkg
// Shared types and defaults for the clock period meter.
//   meas_state_t        - acquisition/lock state of the meter FSM
//   DEFAULT_SYNC_STAGES - default depth of the sig_in synchronizer
// ---------------------------------------------------------------------------
package clk_meas_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ACQ1,
        ACQ2,
        LOCK_WAIT,
        LOCKED
    } meas_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : clk_meas_pkg

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer for a single asynchronous bit.
//   clock_in : destination clock
//   reset    : asynchronous, active-high; clears the whole chain to 0
//   d        : asynchronous input bit
//   q        : synchronized output (STAGES clock_in cycles of latency)
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbour; with = the chain would collapse.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : bit_sync

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
// Measures high phase, low phase and period of a slow square wave in
// reference clock cycles, with lock and loss-of-signal indication.
//   clock_in    : reference clock, rising edge
//   reset       : asynchronous, active-high
//   sig_in      : measured signal, asynchronous to clock_in
//   high_cycles : length of the last complete high phase
//   low_cycles  : length of the last complete low phase
//   period      : high_cycles + low_cycles
//   valid       : one-cycle pulse when the measurement outputs update
//   locked      : measurements reflect complete phases
//   timeout     : no edge seen for TIMEOUT cycles, held until next edge
// ---------------------------------------------------------------------------
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W:0]   period,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    // Saturation value of the phase counter; reaching it with no edge
    // means TIMEOUT edge-free cycles have elapsed.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic             sig_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_len;
    logic             timeout_hit;

    meas_state_t      state;
    meas_state_t      state_next;
    logic             store;
    logic             publish;

    // ---------------- input path ----------------
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .d        (sig_in),
        .q        (s)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign sig_edge = rise | fall;

    // ---------------- phase counter ----------------
    // Counts cycles since the last edge; holds at CNT_MAX instead of
    // wrapping so a dead input cannot alias to a short phase.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (sig_edge) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The edge cycle itself belongs to the phase that is ending.
    assign phase_len = cnt + 1'b1;

    // In HUNT there is nothing to lose; an edge in the same cycle wins.
    assign timeout_hit = (state != HUNT) && !sig_edge && (cnt == CNT_MAX);

    // ---------------- FSM ----------------
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        store      = 1'b0;
        publish    = 1'b0;

        case (state)
            HUNT: begin
                if (sig_edge) state_next = ACQ1;
            end
            ACQ1: begin
                if (sig_edge) state_next = ACQ2;
            end
            ACQ2: begin
                if (sig_edge) begin
                    store      = 1'b1;
                    state_next = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                if (sig_edge) begin
                    store      = 1'b1;
                    publish    = 1'b1;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (sig_edge) begin
                    store   = 1'b1;
                    publish = 1'b1;
                end
            end
            default: state_next = HUNT;
        endcase

        if (timeout_hit) state_next = HUNT;
    end

    // ---------------- capture and status registers ----------------
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            high_cycles <= '0;
            low_cycles  <= '0;
            period      <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else if (timeout_hit) begin
            high_cycles <= '0;
            low_cycles  <= '0;
            period      <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b1;
        end else begin
            valid <= publish;
            if (sig_edge) timeout <= 1'b0;
            if (publish)  locked  <= 1'b1;
            if (store) begin
                // A fall ends a high phase, a rise ends a low phase; period
                // pairs the fresh phase with the opposite held one.
                if (fall) begin
                    high_cycles <= phase_len;
                    period      <= {1'b0, phase_len} + {1'b0, low_cycles};
                end else if (rise) begin
                    low_cycles  <= phase_len;
                    period      <= {1'b0, phase_len} + {1'b0, high_cycles};
                end
            end
        end
    end

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
// Directed waveforms on sig_in; a reference model of edges and phases pushes
// expected measurements into a scoreboard that a monitor drains on valid.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W       = 8;
    localparam int TIMEOUT     = 20;
    localparam int SYNC_STAGES = 2;
    localparam int TO_EDGES    = SYNC_STAGES + 1 + TIMEOUT;

    logic             clock_in;
    logic             reset;
    logic             sig_in;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic [CNT_W:0]   period;
    logic             valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .period      (period),
        .valid       (valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        int h;
        int l;
        int p;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int   m_edges;
    int   m_high;
    int   m_low;
    logic m_lvl;
    int   m_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input logic lvl);
        m_edges = 0;
        m_high  = 0;
        m_low   = 0;
        m_lvl   = lvl;
        m_len   = 0;
    endtask

    // Model a new level on sig_in held for n cycles.
    task automatic model_level(input logic lvl, input int n);
        exp_t e;
        if (lvl != m_lvl) begin
            m_edges++;
            if (m_edges >= 3) begin
                if (m_lvl) m_high = m_len;
                else       m_low  = m_len;
            end
            if (m_edges >= 4) begin
                e.h = m_high;
                e.l = m_low;
                e.p = m_high + m_low;
                sb_q.push_back(e);
            end
            m_lvl = lvl;
            m_len = n;
        end else begin
            m_len += n;
        end
    endtask

    // Called at posedge+1; holds lvl for exactly n cycles.
    task automatic drive(input logic lvl, input int n);
        model_level(lvl, n);
        sig_in = lvl;
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // Monitor: pops one expectation per valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            #1;
            if (valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("high_cycles", 32'(high_cycles), 32'(e.h));
                    check("low_cycles",  32'(low_cycles),  32'(e.l));
                    check("period",      32'(period),      32'(e.p));
                    check("locked_on_valid", 32'(locked),  32'd1);
                end
            end
        end
    end

    initial begin
        int k_hit;

        reset  = 1'b1;
        sig_in = 1'b0;
        model_reset(1'b0);
        #12;
        check("reset_high",    32'(high_cycles), 32'd0);
        check("reset_low",     32'(low_cycles),  32'd0);
        check("reset_period",  32'(period),      32'd0);
        check("reset_valid",   32'(valid),       32'd0);
        check("reset_locked",  32'(locked),      32'd0);
        check("reset_timeout", 32'(timeout),     32'd0);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        @(posedge clock_in);
        #1;

        // divider SCALE=2
        for (int i = 0; i < 12; i++) drive((i % 2) == 0, 2);
        drive(1'b1, 5);

        // asynchronous reset in the middle of a locked high phase
        check("locked_before_reset", 32'(locked), 32'd1);
        check("sb_drained_before_reset", 32'(sb_q.size()), 32'd0);
        #2;
        reset  = 1'b1;
        sig_in = 1'b0;
        model_reset(1'b0);
        #1;
        check("async_reset_high",   32'(high_cycles), 32'd0);
        check("async_reset_low",    32'(low_cycles),  32'd0);
        check("async_reset_period", 32'(period),      32'd0);
        check("async_reset_locked", 32'(locked),      32'd0);
        check("async_reset_valid",  32'(valid),       32'd0);
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;

        // divider SCALE=5, first valid only on the 4th edge
        for (int i = 0; i < 10; i++) drive((i % 2) == 0, 5);

        // 3 high / 7 low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end

        // loss of signal: last edge then hold low
        drive(1'b1, 3);
        model_level(1'b0, 0);
        sig_in = 1'b0;
        k_hit  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock_in);
            #1;
            if (timeout && k_hit == 0) k_hit = k;
        end
        check("timeout_latency", 32'(k_hit), 32'(TO_EDGES));
        check("timeout_level",   32'(timeout),     32'd1);
        check("timeout_locked",  32'(locked),      32'd0);
        check("timeout_high",    32'(high_cycles), 32'd0);
        check("timeout_low",     32'(low_cycles),  32'd0);
        check("timeout_period",  32'(period),      32'd0);
        model_reset(1'b0);

        // resume: timeout clears on first edge, lock on the 4th
        drive(1'b1, 3);
        check("timeout_cleared", 32'(timeout), 32'd0);
        check("not_locked_edge1", 32'(locked), 32'd0);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 3);

        // 1-cycle high pulses every 2 cycles
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        repeat (6) @(posedge clock_in);
        #1;
        check("final_locked", 32'(locked), 32'd1);
        check("sb_drained_at_end", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want completion before 200000");
        $fatal(1);
    end

endmodule : tb_clk_period_meter
